// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the hard-wired zero register index,
// the opaque control bundle type and the ID/EX slot occupancy states.
// No logic; imported by the operand stage and its forwarding mux.
package pipe_pkg;

    localparam int PIPE_ADDR_WIDTH = 5;
    localparam int PIPE_DATA_WIDTH = 32;
    localparam int PIPE_CTRL_WIDTH = 16;

    localparam logic [PIPE_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef logic [PIPE_CTRL_WIDTH-1:0] ctrl_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select: zero register, then EX, MEM, WB bypass, then register file data.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the EX candidate with its own valid.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = PIPE_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic                  ex_vld,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_dat,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_dat,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_dat,
    input  logic [DATA_WIDTH-1:0] rf_dat,
    output logic [DATA_WIDTH-1:0] op
);

    logic rs_zero;

    assign rs_zero = (rs == ADDR_WIDTH'(REG_ZERO));

    // Youngest producer wins; the zero register is checked first so no source can alias it.
    always_comb begin
        op = rf_dat;
        if (rs_zero) begin
            op = '0;
        end else if (ex_vld && (ex_rd == rs)) begin
            op = ex_dat;
        end else if (mem_wen && (mem_rd == rs)) begin
            op = mem_dat;
        end else if (wb_wen && (wb_rd == rs)) begin
            op = wb_dat;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode operand stage: register file read, EX/MEM/WB bypass, load-use stall, ID/EX register.
// Latency: one cycle from accept to out_*.
// Backpressure: holds ID/EX while out_ready=0; in_ready drops on stall, flush or full slot.
module id_operand_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = PIPE_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic                  wb_wen,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_wen,
    output logic                  out_is_load,
    output logic [CTRL_WIDTH-1:0] out_ctrl
);

    slot_state_e           state_q;
    slot_state_e           state_d;
    logic                  ex_fwd_vld;
    logic                  load_use;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1_fwd;
    logic [DATA_WIDTH-1:0] op2_fwd;

    assign raddr1    = in_rs1;
    assign raddr2    = in_rs2;
    assign out_valid = (state_q == SLOT_FULL);

    // A load in ID/EX has no data yet, so it is never an EX bypass source; it stalls instead.
    assign ex_fwd_vld = out_valid && out_rd_wen && !out_is_load;

    assign load_use = out_valid && out_is_load && out_rd_wen &&
                      (out_rd != ADDR_WIDTH'(REG_ZERO)) &&
                      ((out_rd == in_rs1) || (out_rd == in_rs2));

    assign in_ready = !flush && !load_use && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    fwd_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_op1 (
        .rs      (in_rs1),
        .ex_vld  (ex_fwd_vld),
        .ex_rd   (out_rd),
        .ex_dat  (ex_result),
        .mem_wen (mem_wen),
        .mem_rd  (mem_rd),
        .mem_dat (mem_data),
        .wb_wen  (wb_wen),
        .wb_rd   (wb_rd),
        .wb_dat  (wb_data),
        .rf_dat  (rdata1),
        .op      (op1_fwd)
    );

    fwd_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_op2 (
        .rs      (in_rs2),
        .ex_vld  (ex_fwd_vld),
        .ex_rd   (out_rd),
        .ex_dat  (ex_result),
        .mem_wen (mem_wen),
        .mem_rd  (mem_rd),
        .mem_dat (mem_data),
        .wb_wen  (wb_wen),
        .wb_rd   (wb_rd),
        .wb_dat  (wb_data),
        .rf_dat  (rdata2),
        .op      (op2_fwd)
    );

    // Flush dominates; a drained slot with no new accept becomes a bubble.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (accept) begin
            state_d = SLOT_FULL;
        end else if (out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_rd_wen  <= 1'b0;
            out_is_load <= 1'b0;
            out_ctrl    <= '0;
        end else if (accept) begin
            out_op1     <= op1_fwd;
            out_op2     <= op2_fwd;
            out_rd      <= in_rd;
            out_rd_wen  <= in_rd_wen;
            out_is_load <= in_is_load;
            out_ctrl    <= in_ctrl;
        end
    end

endmodule
